// File: rtl/coin_pkg.sv
// Shared types, block geometry and score helper for the coin block controller.
package coin_pkg;

  localparam int NUM_BLK = 4;

  localparam int COIN_H  = 16;
  localparam int BLK_W   = 16;
  localparam int MARIO_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    TALLY = 3'd3,
    ABORT = 3'd4
  } state_t;

  // Block placement in world coordinates; blocks 0 and 1 sit side by side.
  localparam logic [12:0] BLK_X     [NUM_BLK] = '{13'd384, 13'd400, 13'd800, 13'd1200};
  localparam logic [9:0]  BLK_Y_TOP [NUM_BLK] = '{10'd160, 10'd160, 10'd96,  10'd200};
  localparam logic [9:0]  BLK_Y_BOT [NUM_BLK] = '{10'd176, 10'd176, 10'd112, 10'd216};

  // Two-digit BCD increment that sticks at 99.
  function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99)
      r = v;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/coin_block_ctrl_bcd.sv
// Two-digit saturating BCD score counter.
module bcd_counter2
  import coin_pkg::*;
(
  input  logic       clk_pixel,
  input  logic       sys_rst,
  input  logic       inc,
  output logic [7:0] count
);

  // Score register: cleared on reset, one BCD step per inc pulse.
  always_ff @(posedge clk_pixel) begin
    if (sys_rst)
      count <= 8'h00;
    else if (inc)
      count <= bcd_inc_sat(count);
  end

endmodule

// File: rtl/coin_block_ctrl.sv
// Coin block controller: detects head hits on unused blocks, drives the
// shared coin animator through one rise-and-fall, then scores and retires
// the block.
//
//   state | meaning
//   IDLE  | waiting for a frame with a head hit
//   LOAD  | one-cycle animator reset, spawn coordinates already stable
//   RUN   | animation in flight, frames counted for the watchdog
//   TALLY | coin returned home: retire block, add one to the score
//   ABORT | watchdog expired: retire block, score unchanged
module coin_block_ctrl
  import coin_pkg::*;
#(
  parameter int NUM_BLOCKS = NUM_BLK,
  parameter int RISE_PX    = 48,
  parameter int HIT_TOL    = 4,
  parameter int MAX_FRAMES = 63
) (
  input  logic                  clk_pixel,
  input  logic                  sys_rst,
  input  logic                  new_frame,
  input  logic [12:0]           mario_x,
  input  logic [9:0]            mario_y_top,
  input  logic                  mario_rising,
  input  logic                  coin_up,
  input  logic [9:0]            coin_y_in,
  output logic                  coin_anim_rst,
  output logic                  coin_effect,
  output logic [12:0]           coin_x_start,
  output logic [9:0]            coin_y_start,
  output logic [9:0]            coin_y_end,
  output logic                  coin_visible,
  output logic [NUM_BLOCKS-1:0] blocks_used,
  output logic [7:0]            coin_count_bcd,
  output logic                  busy
);

  localparam int IDXW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int FCW  = $clog2(MAX_FRAMES + 1);

  state_t          state, state_nxt;
  logic [IDXW-1:0] idx;
  logic [FCW-1:0]  frame_cnt;
  logic            hit;
  logic [IDXW-1:0] hit_idx;
  logic            tally;

  // Head-hit search; scanning downward lets the lowest index win.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_BLOCKS - 1; i >= 0; i--) begin
      if (!blocks_used[i] && mario_rising
          && ({1'b0, mario_y_top} >= {1'b0, BLK_Y_BOT[i]})
          && ({1'b0, mario_y_top} <= {1'b0, BLK_Y_BOT[i]} + 11'(HIT_TOL))
          && ({1'b0, mario_x} + 14'(MARIO_W) > {1'b0, BLK_X[i]})
          && ({1'b0, mario_x} < {1'b0, BLK_X[i]} + 14'(BLK_W))) begin
        hit     = 1'b1;
        hit_idx = IDXW'(i);
      end
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nxt     = state;
    coin_anim_rst = 1'b0;
    coin_effect   = 1'b0;
    coin_visible  = 1'b0;
    tally         = 1'b0;
    case (state)
      IDLE: begin
        if (new_frame && hit)
          state_nxt = LOAD;
      end
      LOAD: begin
        coin_anim_rst = 1'b1;
        state_nxt     = RUN;
      end
      RUN: begin
        coin_effect  = 1'b1;
        coin_visible = 1'b1;
        // A coin that is home wins over a watchdog expiring the same cycle.
        if (coin_up && (coin_y_in == coin_y_start))
          state_nxt = TALLY;
        else if (frame_cnt == FCW'(MAX_FRAMES))
          state_nxt = ABORT;
      end
      TALLY: begin
        tally     = 1'b1;
        state_nxt = IDLE;
      end
      ABORT: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // State register.
  always_ff @(posedge clk_pixel) begin
    if (sys_rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Spawn latch, watchdog frame counter and block retirement.
  always_ff @(posedge clk_pixel) begin
    if (sys_rst) begin
      idx          <= '0;
      frame_cnt    <= '0;
      coin_x_start <= '0;
      coin_y_start <= '0;
      coin_y_end   <= '0;
      blocks_used  <= '0;
    end else begin
      if (state == IDLE && new_frame && hit) begin
        idx          <= hit_idx;
        coin_x_start <= BLK_X[hit_idx];
        coin_y_start <= BLK_Y_TOP[hit_idx] - 10'(COIN_H);
        coin_y_end   <= BLK_Y_TOP[hit_idx] - 10'(COIN_H) - 10'(RISE_PX);
      end
      if (state == RUN)
        frame_cnt <= frame_cnt + FCW'(new_frame);
      else
        frame_cnt <= '0;
      if (state == TALLY || state == ABORT)
        blocks_used[idx] <= 1'b1;
    end
  end

  bcd_counter2 u_score (
    .clk_pixel (clk_pixel),
    .sys_rst   (sys_rst),
    .inc       (tally),
    .count     (coin_count_bcd)
  );

endmodule

// File: tb/tb_coin_block_ctrl.sv
// Self-checking bench for coin_block_ctrl with a behavioural reference model
// and a simple coin animator stand-in.
module tb_coin_block_ctrl;

  logic        clk_pixel = 1'b0;
  logic        sys_rst = 1'b1;
  logic        new_frame = 1'b0;
  logic [12:0] mario_x = '0;
  logic [9:0]  mario_y_top = '0;
  logic        mario_rising = 1'b0;
  logic        coin_up = 1'b0;
  logic [9:0]  coin_y_in = '0;
  logic        coin_anim_rst, coin_effect, coin_visible, busy;
  logic [12:0] coin_x_start;
  logic [9:0]  coin_y_start, coin_y_end;
  logic [3:0]  blocks_used;
  logic [7:0]  coin_count_bcd;

  logic        b_rst = 1'b1;
  logic        b_inc = 1'b0;
  logic [7:0]  b_count;

  always #5 clk_pixel = ~clk_pixel;

  coin_block_ctrl dut (
    .clk_pixel      (clk_pixel),
    .sys_rst        (sys_rst),
    .new_frame      (new_frame),
    .mario_x        (mario_x),
    .mario_y_top    (mario_y_top),
    .mario_rising   (mario_rising),
    .coin_up        (coin_up),
    .coin_y_in      (coin_y_in),
    .coin_anim_rst  (coin_anim_rst),
    .coin_effect    (coin_effect),
    .coin_x_start   (coin_x_start),
    .coin_y_start   (coin_y_start),
    .coin_y_end     (coin_y_end),
    .coin_visible   (coin_visible),
    .blocks_used    (blocks_used),
    .coin_count_bcd (coin_count_bcd),
    .busy           (busy)
  );

  bcd_counter2 u_bcd (
    .clk_pixel (clk_pixel),
    .sys_rst   (b_rst),
    .inc       (b_inc),
    .count     (b_count)
  );

  // Independent copy of the block layout.
  int tb_x  [4] = '{384, 400, 800, 1200};
  int tb_yt [4] = '{160, 160, 96, 200};
  int tb_yb [4] = '{176, 176, 112, 216};

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  function automatic int to_bcd(input int s);
    return (s / 10) * 16 + (s % 10);
  endfunction

  // ---------------- reference model ----------------
  // Phases of one coin transaction as seen from outside.
  localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_DONE_OK = 3, P_DONE_STUCK = 4;
  int       m_ph = P_IDLE, m_idx = 0, m_frames = 0;
  int       m_xs = 0, m_ys = 0, m_ye = 0, m_score = 0;
  bit [3:0] m_used = '0;
  int       m_w;

  always @(posedge clk_pixel) begin
    if (sys_rst) begin
      m_ph = P_IDLE; m_idx = 0; m_frames = 0;
      m_xs = 0; m_ys = 0; m_ye = 0; m_score = 0; m_used = '0;
    end else begin
      case (m_ph)
        P_IDLE: if (new_frame) begin
          m_w = -1;
          for (int i = 0; i < 4; i++)
            if (m_w < 0 && !m_used[i] && mario_rising
                && int'(mario_y_top) >= tb_yb[i] && int'(mario_y_top) <= tb_yb[i] + 4
                && int'(mario_x) + 16 > tb_x[i] && int'(mario_x) < tb_x[i] + 16)
              m_w = i;
          if (m_w >= 0) begin
            m_idx = m_w;
            m_xs  = tb_x[m_w];
            m_ys  = tb_yt[m_w] - 16;
            m_ye  = m_ys - 48;
            m_ph  = P_LOAD;
          end
        end
        P_LOAD: begin m_frames = 0; m_ph = P_RUN; end
        P_RUN: begin
          if (coin_up && int'(coin_y_in) == m_ys) m_ph = P_DONE_OK;
          else if (m_frames == 63) m_ph = P_DONE_STUCK;
          if (new_frame) m_frames++;
        end
        P_DONE_OK: begin
          m_used[m_idx] = 1'b1;
          if (m_score < 99) m_score++;
          m_ph = P_IDLE;
        end
        default: begin m_used[m_idx] = 1'b1; m_ph = P_IDLE; end
      endcase
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk_pixel) begin
    if (chk_en) begin
      check("anim_rst", coin_anim_rst, int'(m_ph == P_LOAD));
      check("effect",   coin_effect,   int'(m_ph == P_RUN));
      check("visible",  coin_visible,  int'(m_ph == P_RUN));
      check("busy",     busy,          int'(m_ph != P_IDLE));
      check("x_start",  coin_x_start,  m_xs);
      check("y_start",  coin_y_start,  m_ys);
      check("y_end",    coin_y_end,    m_ye);
      check("used",     blocks_used,   int'(m_used));
      check("count",    coin_count_bcd, to_bcd(m_score));
    end
  end

  // ---------------- animator stand-in and stimulus ----------------
  int a_y = 0, a_ys = 0, a_ye = 0;
  bit a_up = 0, a_stuck = 0, rand_stuck = 0, noise = 0;

  task automatic step(input bit nf, input int x, input int y, input bit rise);
    new_frame    = nf;
    mario_x      = 13'(x);
    mario_y_top  = 10'(y);
    mario_rising = rise;
    if (coin_anim_rst) begin
      a_ys = int'(coin_y_start); a_ye = int'(coin_y_end); a_y = a_ys; a_up = 1'b0;
      if (rand_stuck) a_stuck = ($urandom_range(0, 7) == 0);
    end else if (coin_effect && nf && !a_stuck) begin
      if (!a_up) begin
        a_y -= 8;
        if (a_y <= a_ye) begin a_y = a_ye; a_up = 1'b1; end
      end else begin
        a_y += 8;
        if (a_y >= a_ys) a_y = a_ys;
      end
    end
    if (coin_anim_rst || coin_effect) begin
      coin_up = a_up; coin_y_in = 10'(a_y);
    end else if (noise) begin
      coin_up = 1'($urandom_range(0, 1)); coin_y_in = 10'($urandom_range(0, 1023));
    end
    @(negedge clk_pixel);
  endtask

  task automatic run_to_idle(input int period);
    int k;
    k = 0;
    while (busy && k < 3000) begin
      step((k % period) == 0, 0, 0, 1'b0);
      k++;
    end
    check("run_done_in_budget", busy, 0);
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    step(1'b0, 0, 0, 1'b0);
    step(1'b0, 0, 0, 1'b0);
    sys_rst = 1'b0;
  endtask

  int fcd, bx, bn;

  initial begin
    do_reset();
    chk_en = 1'b1;
    check("rst_count", coin_count_bcd, 0);
    check("rst_used", blocks_used, 0);

    // Single hit on block 0, full rise and fall.
    step(1'b1, 380, 178, 1'b1);
    check("hit_anim_rst", coin_anim_rst, 1);
    check("hit_x_start", coin_x_start, 384);
    check("hit_y_start", coin_y_start, 144);
    check("hit_y_end", coin_y_end, 96);
    check("hit_effect_lat", coin_effect, 0);
    step(1'b0, 0, 0, 1'b0);
    check("run_effect", coin_effect, 1);
    run_to_idle(5);
    check("tally_used", blocks_used, 4'b0001);
    check("tally_count", coin_count_bcd, 8'h01);

    // Used block cannot retrigger.
    step(1'b1, 380, 178, 1'b1);
    check("reuse_no_rst", coin_anim_rst, 0);
    check("reuse_count", coin_count_bcd, 8'h01);

    // Two blocks hit together: lowest index first.
    do_reset();
    check("rst2_used", blocks_used, 0);
    step(1'b1, 390, 178, 1'b1);
    check("dual_first", coin_x_start, 384);
    run_to_idle(5);
    step(1'b1, 390, 178, 1'b1);
    check("dual_second", coin_x_start, 400);
    run_to_idle(5);
    check("dual_used", blocks_used, 4'b0011);
    check("dual_count", coin_count_bcd, 8'h02);

    // Coin never returns: watchdog abort.
    a_stuck = 1'b1;
    step(1'b1, 800, 114, 1'b1);
    check("abort_y_start", coin_y_start, 80);
    check("abort_y_end", coin_y_end, 32);
    run_to_idle(5);
    a_stuck = 1'b0;
    check("abort_used", blocks_used, 4'b0111);
    check("abort_count", coin_count_bcd, 8'h02);
    check("abort_effect", coin_effect, 0);

    // Hit window edges on block 3.
    step(1'b1, 1200, 221, 1'b1); check("edge_y_low", coin_anim_rst, 0);
    step(1'b1, 1200, 215, 1'b1); check("edge_y_high", coin_anim_rst, 0);
    step(1'b1, 1184, 216, 1'b1); check("edge_x_left", coin_anim_rst, 0);
    step(1'b1, 1216, 216, 1'b1); check("edge_x_right", coin_anim_rst, 0);
    step(1'b1, 1200, 216, 1'b0); check("edge_falling", coin_anim_rst, 0);
    step(1'b1, 1185, 220, 1'b1);
    check("edge_hit", coin_anim_rst, 1);
    check("edge_x_start", coin_x_start, 1200);
    check("edge_y_start", coin_y_start, 184);
    for (int i = 0; i < 4; i++) step(1'b0, 0, 0, 1'b0);

    // Reset in the middle of RUN.
    sys_rst = 1'b1;
    step(1'b0, 0, 0, 1'b0);
    check("midrst_effect", coin_effect, 0);
    check("midrst_busy", busy, 0);
    check("midrst_count", coin_count_bcd, 0);
    check("midrst_x", coin_x_start, 0);
    sys_rst = 1'b0;

    // Randomized traffic.
    noise = 1'b1; rand_stuck = 1'b1; fcd = 0;
    for (int n = 0; n < 5000; n++) begin
      if (!busy && (m_used == 4'hf || $urandom_range(0, 999) == 0)) do_reset();
      bx = $urandom_range(0, 3);
      step(fcd == 0,
           tb_x[bx] + $urandom_range(0, 40) - 20,
           tb_yb[bx] + $urandom_range(0, 10) - 3,
           $urandom_range(0, 3) != 0);
      fcd = (fcd == 0) ? $urandom_range(2, 6) : fcd - 1;
    end
    noise = 1'b0; rand_stuck = 1'b0; a_stuck = 1'b0;

    // Score counter carry and saturation.
    b_rst = 1'b1; @(negedge clk_pixel); b_rst = 1'b0;
    check("bcd_rst", b_count, 0);
    bn = 0;
    for (int i = 0; i < 9; i++) begin b_inc = 1'b1; @(negedge clk_pixel); bn++; end
    check("bcd_09", b_count, 8'h09);
    @(negedge clk_pixel); bn++;
    check("bcd_carry", b_count, 8'h10);
    for (int i = 0; i < 120; i++) begin
      b_inc = 1'($urandom_range(0, 3) != 0);
      @(negedge clk_pixel);
      if (b_inc && bn < 99) bn++;
      check("bcd_seq", b_count, to_bcd(bn));
    end
    b_inc = 1'b1;
    while (bn < 99) begin @(negedge clk_pixel); bn++; end
    check("bcd_99", b_count, 8'h99);
    for (int i = 0; i < 3; i++) @(negedge clk_pixel);
    check("bcd_sat", b_count, 8'h99);
    b_inc = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
